// File: rtl/frame_output_pkg.sv
// Shared types and constants for the display-side frame output reader.
// Timing defaults are 640x480@60; the color bars are used only when FRAME_READER_TEST_PATTERN_EN is defined.
package frame_output_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned RGB_W     = 12;
  localparam int unsigned FILL_W    = 6;
  localparam int unsigned BAR_IDX_W = 3;
  localparam int unsigned NUM_BARS  = 8;

  localparam int unsigned DEF_H_ACTIVE   = 640;
  localparam int unsigned DEF_H_FP       = 16;
  localparam int unsigned DEF_H_SYNC     = 96;
  localparam int unsigned DEF_H_BP       = 48;
  localparam int unsigned DEF_V_ACTIVE   = 480;
  localparam int unsigned DEF_V_FP       = 10;
  localparam int unsigned DEF_V_SYNC     = 2;
  localparam int unsigned DEF_V_BP       = 33;
  localparam int unsigned DEF_START_FILL = 16;

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    STREAM    = 2'd1,
    BLANK     = 2'd2
  } rd_state_e;

  // One pipeline slot of video output
  typedef struct packed {
    logic [RGB_W-1:0] rgb;
    logic             de;
    logic             hsync;
    logic             vsync;
  } pix_out_t;

  localparam pix_out_t PIX_IDLE = '{rgb: RGB_W'(0), de: 1'b0, hsync: 1'b1, vsync: 1'b1};

  function automatic logic [RGB_W-1:0] bar_color(input logic [BAR_IDX_W-1:0] idx);
    case (idx)
      3'd0:    bar_color = 12'hFFF;
      3'd1:    bar_color = 12'hFF0;
      3'd2:    bar_color = 12'h0FF;
      3'd3:    bar_color = 12'h0F0;
      3'd4:    bar_color = 12'hF0F;
      3'd5:    bar_color = 12'hF00;
      3'd6:    bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters with sync/active decode, frame-boundary strobes and the registered frame-start pulse.
// FRAME_READER_TEST_PATTERN_EN adds the color-bar index output.
module vga_timing_gen
  import frame_output_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_en,
`ifdef FRAME_READER_TEST_PATTERN_EN
  output logic [BAR_IDX_W-1:0] o_bar_idx_c,
`endif
  output logic                 o_active_c,
  output logic                 o_hsync_c,
  output logic                 o_vsync_c,
  output logic                 o_origin_c,
  output logic                 o_frame_end_c,
  output logic                 o_frame_start
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_last;
  logic             v_last;

  assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
  assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

  // Counters advance only while enabled; the frame-start pulse fires once per (0,0) visit
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_frame_start <= i_en && o_origin_c;
      if (i_en) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_active_c    = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
  assign o_hsync_c     = !((h_cnt >= CNT_W'(HS_START)) && (h_cnt <= CNT_W'(HS_END)));
  assign o_vsync_c     = !((v_cnt >= CNT_W'(VS_START)) && (v_cnt <= CNT_W'(VS_END)));
  assign o_origin_c    = (h_cnt == '0) && (v_cnt == '0);
  assign o_frame_end_c = h_last && v_last;

`ifdef FRAME_READER_TEST_PATTERN_EN
  assign o_bar_idx_c = BAR_IDX_W'(h_cnt / CNT_W'(H_ACTIVE / NUM_BARS));
`endif

endmodule

// File: rtl/frame_output_reader.sv
// Output-FIFO reader: raster timing, pixel pops, 2-stage output pipeline and underflow recovery.
// FRAME_READER_TEST_PATTERN_EN adds i_test_pattern, which replaces video with 8 color bars.
module frame_output_reader
  import frame_output_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned START_FILL = DEF_START_FILL
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_en,
`ifdef FRAME_READER_TEST_PATTERN_EN
  input  logic              i_test_pattern,
`endif
  output logic              o_obuf_rd,
  input  logic [RGB_W-1:0]  i_obuf_data,
  input  logic [FILL_W-1:0] i_obuf_fill,
  input  logic              i_obuf_empty,
  output logic [RGB_W-1:0]  o_rgb,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_de,
  output logic              o_frame_start,
  output logic              o_underflow,
  output logic              o_flush_req
);

  logic             active_0;
  logic             hsync_0;
  logic             vsync_0;
  logic             origin_0;
  logic             frame_end_0;
  logic             tp_c;
  logic [RGB_W-1:0] bar_rgb_c;

  rd_state_e state, state_d;
  logic      stream_c;
  logic      pop_c;
  logic      underflow_c;
  logic      flush_c;

  logic      s1_pop;
  pix_out_t  s1;
  pix_out_t  s2;

`ifdef FRAME_READER_TEST_PATTERN_EN
  logic [BAR_IDX_W-1:0] bar_idx_c;
`endif

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rstn        (i_rstn),
    .i_en          (i_en),
`ifdef FRAME_READER_TEST_PATTERN_EN
    .o_bar_idx_c   (bar_idx_c),
`endif
    .o_active_c    (active_0),
    .o_hsync_c     (hsync_0),
    .o_vsync_c     (vsync_0),
    .o_origin_c    (origin_0),
    .o_frame_end_c (frame_end_0),
    .o_frame_start (o_frame_start)
  );

`ifdef FRAME_READER_TEST_PATTERN_EN
  assign tp_c      = i_test_pattern;
  assign bar_rgb_c = active_0 ? bar_color(bar_idx_c) : RGB_W'(0);
`else
  assign tp_c      = 1'b0;
  assign bar_rgb_c = RGB_W'(0);
`endif

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= SYNC_WAIT;
    else         state <= state_d;
  end

  // Streaming begins in the (0,0) cycle itself, so the start decision and the first pop coincide
  always_comb begin
    state_d     = state;
    pop_c       = 1'b0;
    underflow_c = 1'b0;
    flush_c     = 1'b0;
    stream_c    = (state == STREAM) ||
                  ((state == SYNC_WAIT) && origin_0 && (i_obuf_fill >= FILL_W'(START_FILL)));
    if (tp_c) begin
      state_d = SYNC_WAIT;
    end else if (i_en) begin
      case (state)
        SYNC_WAIT, STREAM: begin
          if (stream_c) begin
            state_d = STREAM;
            if (active_0) begin
              if (i_obuf_empty) begin
                underflow_c = 1'b1;
                state_d     = BLANK;
              end else begin
                pop_c = 1'b1;
              end
            end
          end
        end
        BLANK: begin
          if (frame_end_0) begin
            flush_c = 1'b1;
            state_d = SYNC_WAIT;
          end
        end
        default: state_d = SYNC_WAIT;
      endcase
    end
  end

  // The pop strobe is combinational so popped data lands in stage 1; hold it off during reset
  assign o_obuf_rd = pop_c && i_rstn;

  // Stage 1 carries the timing beside the FIFO read latency; stage 2 drives the pins
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      s1_pop      <= 1'b0;
      s1          <= PIX_IDLE;
      s2          <= PIX_IDLE;
      o_underflow <= 1'b0;
      o_flush_req <= 1'b0;
    end else begin
      o_flush_req <= flush_c;
      if (underflow_c) o_underflow <= 1'b1;
      if (i_en) begin
        s1_pop   <= pop_c;
        s1.rgb   <= bar_rgb_c;
        s1.de    <= active_0;
        s1.hsync <= hsync_0;
        s1.vsync <= vsync_0;
        s2.rgb   <= s1_pop ? i_obuf_data : s1.rgb;
        s2.de    <= s1.de;
        s2.hsync <= s1.hsync;
        s2.vsync <= s1.vsync;
      end
    end
  end

  assign o_rgb   = s2.rgb;
  assign o_de    = s2.de;
  assign o_hsync = s2.hsync;
  assign o_vsync = s2.vsync;

endmodule
